// File: rtl/integer_register_file.sv
// Integer register file: two registered read ports, one write port,
// same-cycle write-to-read bypass, optional hardwired-zero entry 0 and a
// clear sequencer that sweeps zeros through every entry after reset or on
// request. The file reports ready only once the sweep has finished.
module integer_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              re0,
  input  logic [ADDR_W-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              clr_req,
  output logic              ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra bit so the sweep counter never aliases with entry 0.
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;

  // Storage: one write port, two asynchronous read taps feeding the
  // registered outputs (maps to distributed RAM or duplicated banks).
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              fwd_en;
  logic [DATA_W-1:0] rsel0;
  logic [DATA_W-1:0] rsel1;

  // Entry 0 is hardwired to zero when ZERO_REG is set.
  function automatic logic is_zero_entry(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Sequencer state and sweep pointer; reset restarts the sweep from 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic and selection of the single storage write port.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_we  = 1'b0;
    mem_wa  = wa;
    mem_wd  = wd;
    fwd_en  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        // User writes and clear requests are ignored while sweeping.
        mem_we = 1'b1;
        mem_wa = ptr_q[ADDR_W-1:0];
        mem_wd = '0;
        ptr_d  = ptr_q + PTR_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          // A write in the request cycle is dropped and not forwarded.
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else begin
          fwd_en = we;
          mem_we = we && !is_zero_entry(wa);
        end
      end
    endcase
    // Reset overrides everything, including storage writes.
    if (!reset_n) begin
      mem_we = 1'b0;
    end
  end

  // Storage write; no reset on the array, the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Read value selection per port: zero entry, then bypass, then storage.
  always_comb begin
    rsel0 = mem[ra0];
    if (is_zero_entry(ra0)) begin
      rsel0 = '0;
    end else if (fwd_en && (wa == ra0)) begin
      rsel0 = wd;
    end
    rsel1 = mem[ra1];
    if (is_zero_entry(ra1)) begin
      rsel1 = '0;
    end else if (fwd_en && (wa == ra1)) begin
      rsel1 = wd;
    end
  end

  // Registered read ports; reads during the sweep return zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      if (re0) begin
        rd0 <= (state_q == ST_READY) ? rsel0 : '0;
      end
      if (re1) begin
        rd1 <= (state_q == ST_READY) ? rsel1 : '0;
      end
    end
  end

  assign ready = (state_q == ST_READY);

endmodule

// File: tb/tb_integer_register_file.sv
// Bench for integer_register_file: two instances (ZERO_REG=0 and 1) share
// the same stimulus; an abstract model predicts outputs every cycle and a
// few hand-computed literals pin the model.
module tb_integer_register_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        re0, re1, we, clr_req;
  logic [5:0]  ra0, ra1, wa;
  logic [31:0] wd;
  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic        ready_a, ready_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  integer_register_file #(.DATA_W(32), .ADDR_W(6), .ZERO_REG(0)) u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .re0(re0), .ra0(ra0), .rd0(rd0_a),
    .re1(re1), .ra1(ra1), .rd1(rd1_a),
    .we(we), .wa(wa), .wd(wd),
    .clr_req(clr_req), .ready(ready_a)
  );

  integer_register_file #(.DATA_W(32), .ADDR_W(6), .ZERO_REG(1)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .re0(re0), .ra0(ra0), .rd0(rd0_b),
    .re1(re1), .ra1(ra1), .rd1(rd1_b),
    .we(we), .wa(wa), .wd(wd),
    .clr_req(clr_req), .ready(ready_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index k: 0 = plain file, 1 = hardwired-zero file.
  logic [31:0] m_mem [2][64];
  logic [31:0] m_rd0 [2];
  logic [31:0] m_rd1 [2];
  bit          m_clearing = 1'b0;
  int          m_swept = 0;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_read(input int k, input logic [5:0] ra, input bit bypass_ok);
    if (k == 1 && ra == 6'd0) return 32'd0;
    if (bypass_ok && we && wa == ra) return wd;
    return m_mem[k][ra];
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid    = 1'b1;
      m_clearing = 1'b1;
      m_swept    = 0;
      for (int k = 0; k < 2; k++) begin
        m_rd0[k] = 32'd0;
        m_rd1[k] = 32'd0;
      end
    end else if (m_clearing) begin
      for (int k = 0; k < 2; k++) begin
        if (re0) m_rd0[k] = 32'd0;
        if (re1) m_rd1[k] = 32'd0;
      end
      m_swept++;
      if (m_swept == 64) begin
        m_clearing = 1'b0;
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 64; i++) m_mem[k][i] = 32'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (re0) m_rd0[k] = m_read(k, ra0, !clr_req);
        if (re1) m_rd1[k] = m_read(k, ra1, !clr_req);
        if (!clr_req && we && !(k == 1 && wa == 6'd0)) m_mem[k][wa] = wd;
      end
      if (clr_req) begin
        m_clearing = 1'b1;
        m_swept    = 0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("ready_a", {31'd0, ready_a}, {31'd0, !m_clearing});
      chk("ready_b", {31'd0, ready_b}, {31'd0, !m_clearing});
      chk("rd0_a", rd0_a, m_rd0[0]);
      chk("rd1_a", rd1_a, m_rd1[0]);
      chk("rd0_b", rd0_b, m_rd0[1]);
      chk("rd1_b", rd1_b, m_rd1[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    re0 = 1'b0; re1 = 1'b0; we = 1'b0; clr_req = 1'b0;
  endtask

  // Counts edges until ready rises, bounded.
  task automatic wait_ready(input string name, input int exp_edges);
    int n;
    n = 0;
    while (ready_a !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(name, n, exp_edges);
  endtask

  initial begin
    reset_n = 1'b0;
    ra0 = '0; ra1 = '0; wa = '0; wd = '0;
    idle();
    tick();
    tick();
    chk("reset_rd0", rd0_a, 32'd0);
    chk("reset_ready", {31'd0, ready_a}, 32'd0);

    // Reset sweep with a read of entry 17 in progress.
    reset_n = 1'b1;
    re0 = 1'b1; ra0 = 6'd17;
    wait_ready("sweep_edges", 64);
    chk("sweep_rd0", rd0_a, 32'd0);

    // Write then read; rd1 holds while re1=0.
    idle();
    we = 1'b1; wa = 6'd6; wd = 32'hA5A5A5A5;
    tick();
    we = 1'b1; wa = 6'd5; wd = 32'hDEADBEEF;
    re1 = 1'b1; ra1 = 6'd6;
    tick();
    idle();
    re0 = 1'b1; ra0 = 6'd5;
    tick();
    chk("wr_rd0", rd0_a, 32'hDEADBEEF);
    chk("hold_rd1", rd1_a, 32'hA5A5A5A5);

    // Bypass to both ports at once.
    idle();
    we = 1'b1; wa = 6'd9; wd = 32'h12345678;
    re0 = 1'b1; ra0 = 6'd9; re1 = 1'b1; ra1 = 6'd9;
    tick();
    chk("byp_rd0", rd0_a, 32'h12345678);
    chk("byp_rd1", rd1_a, 32'h12345678);
    chk("byp_rd1_z", rd1_b, 32'h12345678);

    // Zero register: write to entry 0, read same cycle and next cycle.
    idle();
    we = 1'b1; wa = 6'd0; wd = 32'hFFFFFFFF;
    re1 = 1'b1; ra1 = 6'd0;
    tick();
    chk("zr_same_z", rd1_b, 32'd0);
    chk("zr_same_nz", rd1_a, 32'hFFFFFFFF);
    we = 1'b0;
    tick();
    chk("zr_next_z", rd1_b, 32'd0);
    chk("zr_next_nz", rd1_a, 32'hFFFFFFFF);

    // Clear request with a colliding write that must be lost.
    idle();
    we = 1'b1; wa = 6'd3; wd = 32'd7;
    tick();
    wa = 6'd40; wd = 32'd8;
    tick();
    we = 1'b1; wa = 6'd3; wd = 32'd99; clr_req = 1'b1;
    re0 = 1'b1; ra0 = 6'd3; re1 = 1'b1; ra1 = 6'd40;
    tick();
    chk("clr_rd0", rd0_a, 32'd7);
    chk("clr_rd1", rd1_a, 32'd8);
    idle();
    wait_ready("clr_edges", 64);
    re0 = 1'b1; ra0 = 6'd3; re1 = 1'b1; ra1 = 6'd40;
    tick();
    chk("post_clr_rd0", rd0_a, 32'd0);
    chk("post_clr_rd1", rd1_a, 32'd0);

    // Reset in the middle of a requested sweep restarts it.
    idle();
    we = 1'b1; wa = 6'd12; wd = 32'h55;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_ready("rst_mid_edges", 64);
    re0 = 1'b1; ra0 = 6'd12;
    tick();
    chk("rst_mid_rd0", rd0_a, 32'd0);

    // Mixed traffic over a small address window to hit collisions.
    for (int i = 0; i < 80; i++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = 6'($urandom_range(0, 7));
      wd  = $urandom;
      re0 = 1'($urandom_range(0, 1));
      ra0 = 6'($urandom_range(0, 7));
      re1 = 1'($urandom_range(0, 1));
      ra1 = 6'($urandom_range(0, 7));
      clr_req = 1'b0;
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integer_register_file.md
Name: integer_register_file

Overview:
Parametrised successor to the integer register file used by the execution core. It has independent synchronous read ports and a dedicated write port, so reads are never blocked by writes. It adds write-to-read bypass, an optional hardwired-zero entry, and a hardware clear sequencer that zeroes every entry after reset or on request. The core must wait for ready before issuing register traffic.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
re0  input  1  read enable, port 0
ra0  input  ADDR_W  read address, port 0
rd0  output  DATA_W  registered read data, port 0
re1  input  1  read enable, port 1
ra1  input  ADDR_W  read address, port 1
rd1  output  DATA_W  registered read data, port 1
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  DATA_W  write data
clr_req  input  1  single-cycle request to re-zero all entries
ready  output  1  1 = file usable; 0 = clear sweep in progress

Behaviour:
- Reset (reset_n=0 at an edge):
  - rd0 = rd1 = 0 and ready = 0.
  - State goes to CLEAR with clear pointer ptr = 0.
  - Reset asserted mid-sweep restarts the sweep from 0.
  - Reset overrides all other inputs.
- State CLEAR:
  - Each edge writes 0 to mem[ptr], then ptr increments.
  - On the edge that clears entry DEPTH-1, the state becomes READY and ready=1.
  - ready therefore rises on the DEPTH-th edge with reset_n=1.
  - we is ignored.
  - clr_req is ignored.
  - Port p with rep=1 loads rdp=0; port p with rep=0 holds rdp.
- State READY:
  - Write: if we=1, mem[wa] <= wd at the edge. The exception is ZERO_REG=1 with wa=0, where the write is dropped.
  - Read, port p:
    - rep=1: rdp updates at the edge (1-cycle latency).
    - rep=0: rdp holds its previous value.
  - Read value, evaluated in this priority order:
    1. ZERO_REG=1 and rap=0 -> 0.
    2. Bypass: we=1 and wa=rap in the same cycle -> wd.
    3. Otherwise -> mem[rap].
  - Both ports may read the same address. Both ports may also bypass the same write simultaneously.
- clr_req=1 in READY:
  - Next state is CLEAR, with ptr=0 and ready=0 after that edge.
  - A write presented in the same cycle is discarded and is not bypassed.
  - Reads in that cycle complete normally, returning the stored mem values.
- Address arithmetic:
  - ptr is ADDR_W+1 bits so the terminal count is detected without wrap ambiguity.
  - All addresses are unsigned and never out of range.
- Storage:
  - No read-modify-write.
  - Storage must infer a RAM or distributed RAM with two read ports. Duplicated banks are acceptable.

Test Plan:
- Reset sweep: reset_n low 2 cycles, then high, DEPTH=64 -> ready=0 for edges 1..63, ready=1 after edge 64; re0=1,ra0=17 during the sweep gives rd0=0.
- Write/read: write wa=5,wd=32'hDEADBEEF; next cycle re0=1,ra0=5 -> rd0=32'hDEADBEEF one edge later; rd1 with re1=0 holds its prior value.
- Bypass: we=1,wa=9,wd=32'h12345678 with re0=re1=1,ra0=ra1=9, mem[9]=0 -> both rd0 and rd1 = 32'h12345678 after the same edge.
- Zero register: ZERO_REG=1, write wa=0,wd=32'hFFFFFFFF, read ra1=0 in the same cycle and in the next cycle -> rd1=0 both times. With ZERO_REG=0 the next-cycle read returns 32'hFFFFFFFF.
- Clear request: fill entries 3 and 40 with 7 and 8, pulse clr_req with we=1,wa=3,wd=99 -> ready low for 64 edges; afterwards reads of 3 and 40 return 0 and the write of 99 is lost.
- Reset mid-sweep: assert reset_n=0 at ptr=30 during a clr_req sweep -> the sweep restarts and ready rises 64 edges after reset_n returns high.
